alu_mdu_ctrl: RTL and testbench

Parametrised successor to the single-cycle ALU operation decoder. Decodes ALUOp/Funct7/Funct3 into the 4-bit ALU Operation code, extended with SUB and SLTU. Adds an iterative RV32M multiply/divide engine with a stall handshake to the EX stage. Sits beside the ALU in EX; its result is muxed onto the ALU result bus when md_valid is high.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/mdu_iter.sv | 124 ++++++++++++
 rtl/alu_mdu_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_mdu_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation decoder and the M-extension engine.
package alu_pkg;

  // 4-bit ALU operation codes driven onto the EX-stage ALU.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_PASS = 4'b0011,  // JAL/LUI pass-through
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_BLT  = 4'b1010,
    OP_BGE  = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_SUB  = 4'b1101,
    OP_SLTU = 4'b1110
  } alu_op_e;

  // ALUOp field from the main decoder.
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  // M-extension Funct3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  // Multiply/divide sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M datapath: shift-add multiply (MUL_STEP bits per cycle) and
// restoring divide (1 bit per cycle) on operand magnitudes, with a final sign fix.
module mdu_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            last,
  output logic [XLEN-1:0] result
);
  import alu_pkg::*;

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] MulLast = CntW'(XLEN / MUL_STEP - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

  // Multiply: {partial high, multiplier shifting out low}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   mcand_q;   // multiplicand magnitude or divisor magnitude
  logic [2:0]        f3_q;
  logic              neg_res_q; // negate product / quotient at the end
  logic              neg_rem_q; // negate remainder at the end
  logic              run_q;
  logic [CntW-1:0]   cnt_q;

  logic              sgn_a, sgn_b, neg_a, neg_b, b_zero;
  logic [XLEN-1:0]   mag_a, mag_b;

  // Operand signedness and magnitudes for the op being accepted.
  always_comb begin
    sgn_a  = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
             (funct3 == F3_DIV) || (funct3 == F3_REM);
    sgn_b  = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
             (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a  = sgn_a && src_a[XLEN-1];
    neg_b  = sgn_b && src_b[XLEN-1];
    mag_a  = neg_a ? -src_a : src_a;
    mag_b  = neg_b ? -src_b : src_b;
    b_zero = (src_b == '0);
  end

  logic [MUL_STEP-1:0]      mbits;
  logic [XLEN+MUL_STEP-1:0] partial, acc;
  logic [2*XLEN-1:0]        mul_next, div_next, step;
  logic [XLEN:0]            shifted, diff;

  // One iteration of whichever algorithm is running.
  always_comb begin
    mbits    = prod_q[MUL_STEP-1:0];
    partial  = {{MUL_STEP{1'b0}}, mcand_q} * {{XLEN{1'b0}}, mbits};
    acc      = {{MUL_STEP{1'b0}}, prod_q[2*XLEN-1:XLEN]} + partial;
    mul_next = {acc, prod_q[XLEN-1:MUL_STEP]};
    shifted  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    diff     = shifted - {1'b0, mcand_q};
    div_next = diff[XLEN] ? {shifted[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    step     = f3_q[2] ? div_next : mul_next;
  end

  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo, rem;

  // Final result as it will stand after this iteration; only sampled on the last one.
  always_comb begin
    mul_fix = neg_res_q ? -step : step;
    quo     = step[XLEN-1:0];
    rem     = step[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                        result = mul_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = mul_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result = neg_res_q ? -quo : quo;
      default:                       result = neg_rem_q ? -rem : rem;
    endcase
  end

  assign last = run_q && (cnt_q == (f3_q[2] ? DivLast : MulLast));

  // Operand latch on start, then one iteration per cycle until the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      mcand_q   <= '0;
      f3_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      run_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (abort) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      f3_q  <= funct3;
      if (funct3[2]) begin
        mcand_q   <= mag_b;
        prod_q    <= {{XLEN{1'b0}}, mag_a};
        // Divide by zero yields all ones regardless of operand signs.
        neg_res_q <= (neg_a ^ neg_b) && !b_zero;
        neg_rem_q <= neg_a;
      end else begin
        mcand_q   <= mag_a;
        prod_q    <= {{XLEN{1'b0}}, mag_b};
        neg_res_q <= neg_a ^ neg_b;
        neg_rem_q <= 1'b0;
      end
    end else if (run_q) begin
      prod_q <= step;
      if (last) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU operation decoder plus stall/handshake control for the iterative M-extension engine.
module alu_mdu_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            RType,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [3:0]      Operation,
  output logic            is_md,
  output logic            stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);
  import alu_pkg::*;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("XLEN must be 32 or 64");
  end
  if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4) || (XLEN % MUL_STEP != 0)) begin : g_bad_step
    $error("MUL_STEP must be 1, 2 or 4 and divide XLEN");
  end

  alu_op_e op;

  assign is_md = (ALUOp == ALUOP_ARITH) && RType && (Funct7 == FUNCT7_MEXT);

  // ALU operation decode; M-ext instructions get ADD since the EX mux ignores it.
  always_comb begin
    op = OP_ADD;
    if (!is_md) begin
      case (ALUOp)
        ALUOP_MEM:  op = OP_ADD;
        ALUOP_JUMP: op = OP_PASS;
        ALUOP_BRANCH: begin
          case (Funct3)
            3'b001:  op = OP_BNE;
            3'b100:  op = OP_BLT;
            3'b101:  op = OP_BGE;
            default: op = OP_BEQ;
          endcase
        end
        default: begin
          case (Funct3)
            3'b000:  op = (RType && (Funct7 == FUNCT7_ALT)) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = (Funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      endcase
    end
  end

  assign Operation = op;

  md_state_e state_q, state_d;
  logic      accept, md_last;
  logic [XLEN-1:0] mdu_res, md_result_q;

  // Only IDLE accepts, so the instruction still held in EX during DONE is not restarted.
  assign accept = (state_q == StIdle) && in_valid && is_md && !flush;

  // Next-state and stall; stall covers the accept cycle and every BUSY cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          stall   = 1'b1;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (flush)        state_d = StIdle;
        else if (md_last) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Capture the finished result on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_result_q <= '0;
    end else if ((state_q == StBusy) && md_last && !flush) begin
      md_result_q <= mdu_res;
    end
  end

  assign md_valid  = (state_q == StDone);
  assign md_result = md_result_q;

  mdu_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .abort  (flush),
    .funct3 (Funct3),
    .src_a  (SrcA),
    .src_b  (SrcB),
    .last   (md_last),
    .result (mdu_res)
  );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench: decoder vector table, directed and randomized M-ext ops against a
// behavioural model, plus flush, reset and back-to-back issue sequences.
module tb_alu_mdu_ctrl;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        RType, in_valid, flush;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  op1, op4;
  logic        md1, md4, stall1, stall4, v1, v4;
  logic [31:0] res1, res4;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_mdu_ctrl #(.XLEN(32), .MUL_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .RType(RType),
    .in_valid(in_valid), .flush(flush), .SrcA(SrcA), .SrcB(SrcB), .Operation(op1),
    .is_md(md1), .stall(stall1), .md_valid(v1), .md_result(res1)
  );

  alu_mdu_ctrl #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .RType(RType),
    .in_valid(in_valid), .flush(flush), .SrcA(SrcA), .SrcB(SrcB), .Operation(op4),
    .is_md(md4), .stall(stall4), .md_valid(v4), .md_result(res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      F3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUOp = ALUOP_ARITH; RType = 1'b1; Funct7 = FUNCT7_MEXT; Funct3 = f3;
    SrcA = a; SrcB = b; in_valid = 1'b1;
  endtask

  // Issue one op for a single cycle, then watch both DUTs for latency and result.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat1, lat4, p1, p4;
    logic [31:0] r1, r4;
    lat1 = 0; lat4 = 0; p1 = 0; p4 = 0; r1 = '0; r4 = '0;
    drive_md(f3, a, b);
    #1;
    check({tag, " accept stall"}, 64'(stall1), 64'(1));
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (v1) begin p1++; if (lat1 == 0) begin lat1 = i; r1 = res1; end end
      if (v4) begin p4++; if (lat4 == 0) begin lat4 = i; r4 = res4; end end
    end
    check({tag, " lat step1"}, 64'(lat1), 64'(33));
    check({tag, " res step1"}, 64'(r1), 64'(exp));
    check({tag, " lat step4"}, 64'(lat4), f3[2] ? 64'(33) : 64'(9));
    check({tag, " res step4"}, 64'(r4), 64'(exp));
    check({tag, " pulses"}, 64'(p1 + p4), 64'(2));
  endtask

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       rtype;
    logic [3:0] op;
    logic       md;
  } dec_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } md_vec_t;

  dec_vec_t dec_tab[21];
  md_vec_t  md_tab[12];

  initial begin
    logic [31:0] ra, rb, got[2], av[2], bv[2];
    logic [2:0]  rf;
    int          pulses, ptr;
    logic        st;

    dec_tab[0]  = '{2'b00, 7'h00, 3'b000, 1'b0, 4'b0010, 1'b0};
    dec_tab[1]  = '{2'b11, 7'h00, 3'b000, 1'b0, 4'b0011, 1'b0};
    dec_tab[2]  = '{2'b01, 7'h00, 3'b000, 1'b0, 4'b1000, 1'b0};
    dec_tab[3]  = '{2'b01, 7'h00, 3'b001, 1'b0, 4'b1001, 1'b0};
    dec_tab[4]  = '{2'b01, 7'h00, 3'b100, 1'b0, 4'b1010, 1'b0};
    dec_tab[5]  = '{2'b01, 7'h00, 3'b101, 1'b0, 4'b1011, 1'b0};
    dec_tab[6]  = '{2'b01, 7'h00, 3'b110, 1'b0, 4'b1000, 1'b0};
    dec_tab[7]  = '{2'b10, 7'h20, 3'b000, 1'b1, 4'b1101, 1'b0};
    dec_tab[8]  = '{2'b10, 7'h20, 3'b000, 1'b0, 4'b0010, 1'b0};
    dec_tab[9]  = '{2'b10, 7'h00, 3'b000, 1'b1, 4'b0010, 1'b0};
    dec_tab[10] = '{2'b10, 7'h00, 3'b001, 1'b1, 4'b0100, 1'b0};
    dec_tab[11] = '{2'b10, 7'h00, 3'b010, 1'b1, 4'b1100, 1'b0};
    dec_tab[12] = '{2'b10, 7'h00, 3'b011, 1'b1, 4'b1110, 1'b0};
    dec_tab[13] = '{2'b10, 7'h00, 3'b100, 1'b1, 4'b0110, 1'b0};
    dec_tab[14] = '{2'b10, 7'h00, 3'b101, 1'b1, 4'b0101, 1'b0};
    dec_tab[15] = '{2'b10, 7'h20, 3'b101, 1'b0, 4'b0111, 1'b0};
    dec_tab[16] = '{2'b10, 7'h00, 3'b110, 1'b1, 4'b0001, 1'b0};
    dec_tab[17] = '{2'b10, 7'h00, 3'b111, 1'b1, 4'b0000, 1'b0};
    dec_tab[18] = '{2'b10, 7'h01, 3'b110, 1'b1, 4'b0010, 1'b1};
    dec_tab[19] = '{2'b10, 7'h01, 3'b000, 1'b0, 4'b0010, 1'b0};
    dec_tab[20] = '{2'b11, 7'h01, 3'b000, 1'b1, 4'b0011, 1'b0};

    md_tab[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    md_tab[1]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    md_tab[2]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    md_tab[3]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    md_tab[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    md_tab[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    md_tab[6]  = '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    md_tab[7]  = '{F3_REMU,   32'd5,          32'd0,         32'd5};
    md_tab[8]  = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    md_tab[9]  = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    md_tab[10] = '{F3_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
    md_tab[11] = '{F3_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ALUOp = '0; Funct7 = '0; Funct3 = '0;
    RType = 1'b0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    check("reset stall", 64'(stall1), 64'(0));
    check("reset md_valid", 64'(v1), 64'(0));
    check("reset md_result", 64'(res1), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Decoder table (no accepts: in_valid low).
    foreach (dec_tab[i]) begin
      ALUOp = dec_tab[i].aluop; Funct7 = dec_tab[i].f7; Funct3 = dec_tab[i].f3;
      RType = dec_tab[i].rtype;
      #1;
      check($sformatf("dec[%0d] Operation", i), 64'(op1), 64'(dec_tab[i].op));
      check($sformatf("dec[%0d] is_md", i), 64'(md1), 64'(dec_tab[i].md));
      @(negedge clk);
    end

    // Directed M-ext vectors.
    foreach (md_tab[i]) begin
      run_md($sformatf("md[%0d]", i), md_tab[i].f3, md_tab[i].a, md_tab[i].b, md_tab[i].exp);
    end

    // Randomized ops against the model.
    for (int k = 0; k < 30; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_md($sformatf("rnd[%0d] f3=%0d a=%h b=%h", k, rf, ra, rb), rf, ra, rb, ref_md(rf, ra, rb));
    end

    // Flush during BUSY cycle 10 of a DIV.
    drive_md(F3_DIV, 32'd100, 32'd7);
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (i == 10) flush = 1'b1;
      if (i == 11) begin
        flush = 1'b0;
        #1;
        check("flush stall", 64'(stall1), 64'(0));
        check("flush md_valid", 64'(v1), 64'(0));
      end
      if (v1) pulses++;
    end
    check("flush pulses", 64'(pulses), 64'(0));
    run_md("post-flush mul", F3_MUL, 32'h0001_2345, 32'h0000_6789,
           ref_md(F3_MUL, 32'h0001_2345, 32'h0000_6789));

    // Asynchronous reset mid-operation.
    drive_md(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      if (i == 5) begin
        rst_n = 1'b0;
        #1;
        check("rst stall", 64'(stall1), 64'(0));
        check("rst md_valid", 64'(v1), 64'(0));
        check("rst md_result", 64'(res1), 64'(0));
        check("rst md_result step4", 64'(res4), 64'(0));
      end
      if (i == 6) rst_n = 1'b1;
      if (v1) pulses++;
    end
    check("rst pulses", 64'(pulses), 64'(0));

    // Pipeline-style issue: instruction held while stalled, next MUL follows DONE directly.
    av[0] = 32'hFFFF_FFF0; bv[0] = 32'd9;
    av[1] = 32'h0000_1000; bv[1] = 32'h0000_3000;
    got[0] = '0; got[1] = '0;
    pulses = 0; ptr = 0;
    for (int c = 0; c < 120; c++) begin
      if (ptr < 2) drive_md(F3_MUL, av[ptr], bv[ptr]);
      else in_valid = 1'b0;
      #1;
      st = stall1;
      @(negedge clk);
      if (v1) begin
        if (pulses < 2) got[pulses] = res1;
        pulses++;
      end
      if (ptr < 2 && !st) ptr++;
    end
    check("b2b pulses", 64'(pulses), 64'(2));
    check("b2b res0", 64'(got[0]), 64'(ref_md(F3_MUL, av[0], bv[0])));
    check("b2b res1", 64'(got[1]), 64'(ref_md(F3_MUL, av[1], bv[1])));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
